// File: rtl/fb_pkg.sv
// fb_pkg: types and constants shared by the framebuffer scan-out path and
// the upstream framebuffer writer.
//   FB_ADDR_W / FB_DATA_W / FB_DEPTH : framebuffer geometry (4096 x 8)
//   fb_pix_t                         : one streamed byte plus its markers
//   fb_scan_state_e                  : scan-out sequencer states
//   fb_cnt_w()                       : counter width for a 0..n-1 range
package fb_pkg;

  localparam int FB_ADDR_W = 12;
  localparam int FB_DATA_W = 8;
  localparam int FB_DEPTH  = 4096;

  typedef struct packed {
    logic [FB_DATA_W-1:0] data;
    logic [1:0]           chan;
    logic                 sof;
    logic                 sol;
  } fb_pix_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } fb_scan_state_e;

  function automatic int fb_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fb_skid_fifo.sv
// fb_skid_fifo: 2-entry valid/ready FIFO of fb_pix_t.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_push     : write i_din (caller guarantees space)
//   i_din      : entry to write
//   i_pop      : consume head entry (ignored when empty)
//   o_dout     : head entry
//   o_valid    : FIFO not empty
//   o_count    : occupancy 0..2
module fb_skid_fifo
  import fb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push,
  input  fb_pix_t    i_din,
  input  logic       i_pop,
  output fb_pix_t    o_dout,
  output logic       o_valid,
  output logic [1:0] o_count
);

  fb_pix_t    r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;
  logic       w_pop;

  assign w_pop = i_pop && (r_count != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem    <= '{default: '0};
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_valid = (r_count != 2'd0);
  assign o_count = r_count;

endmodule

// File: rtl/fb_scanout.sv
// fb_scanout: reads a COLS x ROWS x CHANS frame from the framebuffer read
// port in raster order and streams it out as a valid/ready byte stream.
//   clkb       : clock (shared with framebuffer port B)
//   reset      : asynchronous active-low reset
//   start      : frame request, honoured only while busy=0
//   busy       : frame scan in progress
//   frame_done : one-cycle pulse after the final byte is accepted
//   addrb      : framebuffer read address (registered)
//   doutb      : framebuffer read data, one cycle after addrb is sampled
//   pix_*      : output stream (data, channel, start-of-frame/line, valid)
//   pix_ready  : consumer handshake
module fb_scanout
  import fb_pkg::*;
#(
  parameter int COLS      = 32,
  parameter int ROWS      = 32,
  parameter int CHANS     = 3,
  parameter int BASE_ADDR = 0
) (
  input  logic                 clkb,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 frame_done,
  output logic [FB_ADDR_W-1:0] addrb,
  input  logic [FB_DATA_W-1:0] doutb,
  output logic [FB_DATA_W-1:0] pix_data,
  output logic [1:0]           pix_chan,
  output logic                 pix_sof,
  output logic                 pix_sol,
  output logic                 pix_valid,
  input  logic                 pix_ready
);

  localparam int NBYTES = COLS * ROWS * CHANS;
  localparam int COL_W  = fb_cnt_w(COLS);
  localparam int ROW_W  = fb_cnt_w(ROWS);
  localparam logic [FB_ADDR_W-1:0] BASE = FB_ADDR_W'(BASE_ADDR);

  if (BASE_ADDR + NBYTES > FB_DEPTH) begin : g_bad_range
    $error("fb_scanout: BASE_ADDR + COLS*ROWS*CHANS exceeds framebuffer depth");
  end
  if (CHANS < 1 || CHANS > 4) begin : g_bad_chans
    $error("fb_scanout: CHANS must be 1..4");
  end

  fb_scan_state_e       r_state;
  logic [FB_ADDR_W-1:0] r_addr;
  logic [1:0]           r_chan;
  logic [COL_W-1:0]     r_col;
  logic [ROW_W-1:0]     r_row;
  logic                 r_busy;
  logic                 r_frame_done;
  // Read in flight through the framebuffer's registered output
  logic                 r_rd_vld;
  logic [1:0]           r_rd_chan;
  logic                 r_rd_sof;
  logic                 r_rd_sol;

  fb_pix_t              w_push_pix;
  fb_pix_t              w_head;
  logic                 w_fifo_valid;
  logic [1:0]           w_fifo_count;
  logic                 w_pop;
  logic [2:0]           w_pending;
  logic                 w_issue;
  logic                 w_chan_last;
  logic                 w_col_last;
  logic                 w_row_last;
  logic                 w_last;
  logic                 w_is_sol;
  logic                 w_is_sof;
  logic                 w_drain_done;

  assign w_pop = w_fifo_valid && pix_ready;

  // Bytes held or owed after this cycle: FIFO plus in-flight, minus the one
  // leaving now. Keeping this below 2 before issuing means a read can never
  // land on a full FIFO, whatever pix_ready does.
  assign w_pending = {1'b0, w_fifo_count} + {2'b00, r_rd_vld} - {2'b00, w_pop};
  assign w_issue   = (r_state == ST_ISSUE) && (w_pending < 3'd2);

  assign w_chan_last = (r_chan == 2'(CHANS - 1));
  assign w_col_last  = (r_col == COL_W'(COLS - 1));
  assign w_row_last  = (r_row == ROW_W'(ROWS - 1));
  assign w_last      = w_chan_last && w_col_last && w_row_last;
  assign w_is_sol    = (r_col == '0) && (r_chan == 2'd0);
  assign w_is_sof    = w_is_sol && (r_row == '0);

  // No reads are issued in DRAIN, so the final byte is the one popped while
  // it is the only byte left in the FIFO and nothing is in flight.
  assign w_drain_done = (r_state == ST_DRAIN) && w_pop &&
                        (w_fifo_count == 2'd1) && !r_rd_vld;

  assign w_push_pix = '{data: doutb, chan: r_rd_chan, sof: r_rd_sof, sol: r_rd_sol};

  always_ff @(posedge clkb or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_addr       <= BASE;
      r_chan       <= '0;
      r_col        <= '0;
      r_row        <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_rd_vld     <= 1'b0;
      r_rd_chan    <= '0;
      r_rd_sof     <= 1'b0;
      r_rd_sol     <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_rd_vld     <= w_issue;
      if (w_issue) begin
        r_rd_chan <= r_chan;
        r_rd_sof  <= w_is_sof;
        r_rd_sol  <= w_is_sol;
      end

      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_ISSUE;
            r_busy  <= 1'b1;
            r_addr  <= BASE;
            r_chan  <= '0;
            r_col   <= '0;
            r_row   <= '0;
          end
        end

        ST_ISSUE: begin
          if (w_issue) begin
            if (w_last) begin
              // addrb keeps the last issued address until the next start
              r_state <= ST_DRAIN;
            end else begin
              r_addr <= r_addr + 1'b1;
              if (w_chan_last) begin
                r_chan <= '0;
                if (w_col_last) begin
                  r_col <= '0;
                  r_row <= r_row + 1'b1;
                end else begin
                  r_col <= r_col + 1'b1;
                end
              end else begin
                r_chan <= r_chan + 1'b1;
              end
            end
          end
        end

        ST_DRAIN: begin
          if (w_drain_done) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b1;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  fb_skid_fifo u_fifo (
    .clk     (clkb),
    .rst_n   (reset),
    .i_push  (r_rd_vld),
    .i_din   (w_push_pix),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_valid (w_fifo_valid),
    .o_count (w_fifo_count)
  );

  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign addrb      = r_addr;
  assign pix_valid  = w_fifo_valid;
  assign pix_data   = w_head.data;
  assign pix_chan   = w_head.chan;
  assign pix_sof    = w_head.sof;
  assign pix_sol    = w_head.sol;

endmodule

// File: tb/tb_fb_scanout.sv
// tb_fb_scanout: directed bench for fb_scanout. Two instances share clock
// and reset: the default 32x32x3 frame at address 0 and a 4x2x3 frame at
// address 1000. Each framebuffer model returns addr[7:0] one cycle late.
module tb_fb_scanout;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        start_b, ready_b, busy_b, done_b, valid_b, sof_b, sol_b;
  logic [11:0] addr_b;
  logic [7:0]  dout_b, data_b;
  logic [1:0]  chan_b;

  logic        start_s, ready_s, busy_s, done_s, valid_s, sof_s, sol_s;
  logic [11:0] addr_s;
  logic [7:0]  dout_s, data_s;
  logic [1:0]  chan_s;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) dout_b <= addr_b[7:0];
  always @(posedge clk) dout_s <= addr_s[7:0];

  fb_scanout u_big (
    .clkb(clk), .reset(rst_n), .start(start_b), .busy(busy_b),
    .frame_done(done_b), .addrb(addr_b), .doutb(dout_b),
    .pix_data(data_b), .pix_chan(chan_b), .pix_sof(sof_b), .pix_sol(sol_b),
    .pix_valid(valid_b), .pix_ready(ready_b)
  );

  fb_scanout #(.COLS(4), .ROWS(2), .CHANS(3), .BASE_ADDR(1000)) u_small (
    .clkb(clk), .reset(rst_n), .start(start_s), .busy(busy_s),
    .frame_done(done_s), .addrb(addr_s), .doutb(dout_s),
    .pix_data(data_s), .pix_chan(chan_s), .pix_sof(sof_s), .pix_sol(sol_s),
    .pix_valid(valid_s), .pix_ready(ready_s)
  );

  typedef struct {
    logic       start;
    logic       ready;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic [1:0] exp_chan;
    logic       exp_sof;
    logic       exp_sol;
    logic       exp_busy;
    logic       exp_done;
  } vec_t;

  localparam int NVEC = 40;
  vec_t        vecs [NVEC];
  int unsigned k;
  bit          pv;
  bit          acc_now;
  int unsigned seen;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag, input logic [11:0] exp_addr,
                                input logic bsy, input logic dn, input logic [11:0] ad,
                                input logic vl, input logic [7:0] dt, input logic [1:0] ch,
                                input logic so, input logic sl);
    chk({tag, " busy"}, bsy, 0);
    chk({tag, " frame_done"}, dn, 0);
    chk({tag, " addrb"}, ad, exp_addr);
    chk({tag, " pix_valid"}, vl, 0);
    chk({tag, " pix_data"}, dt, 0);
    chk({tag, " pix_chan"}, ch, 0);
    chk({tag, " pix_sof"}, so, 0);
    chk({tag, " pix_sol"}, sl, 0);
  endtask

  // One full frame on the large instance. Called from idle or during the
  // frame_done cycle; returns in the cycle where frame_done is visible.
  task automatic run_frame(input int unsigned duty, input bit poke,
                           input int unsigned exp_done_cyc, input string tag);
    int unsigned acc, cyc, done_cyc;
    int unsigned bad_d, bad_so, bad_sl, bad_ch, bad_st, bad_ld;
    logic [7:0]  prev_data;
    bit          prev_stall, got_done;
    acc = 0; cyc = 0; done_cyc = 0;
    bad_d = 0; bad_so = 0; bad_sl = 0; bad_ch = 0; bad_st = 0; bad_ld = 0;
    prev_data = 8'h00; prev_stall = 0; got_done = 0;

    start_b = 1'b1; ready_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    chk({tag, " busy after start"}, busy_b, 1);
    chk({tag, " addrb after start"}, addr_b, 0);
    chk({tag, " frame_done one cycle"}, done_b, 0);

    while (!got_done && cyc < 20000) begin
      if (prev_stall && (!valid_b || data_b !== prev_data)) bad_st++;
      if (int'(addr_b) - int'(acc) > 2) bad_ld++;
      ready_b = (duty >= 100) ? 1'b1 : ($urandom_range(99, 0) < duty);
      start_b = poke && (cyc == 100);
      if (valid_b && ready_b) begin
        if (data_b !== acc[7:0]) bad_d++;
        if (sof_b !== (acc == 0)) bad_so++;
        if (sol_b !== (acc % 96 == 0)) bad_sl++;
        if (chan_b !== 2'(acc % 3)) bad_ch++;
        acc++;
      end
      prev_stall = valid_b && !ready_b;
      prev_data  = data_b;
      @(posedge clk); #1;
      cyc++;
      if (done_b) begin
        got_done = 1;
        done_cyc = cyc;
      end
    end
    start_b = 1'b0;
    ready_b = 1'b1;

    chk({tag, " frame_done seen"}, got_done, 1);
    chk({tag, " bytes accepted"}, acc, 3072);
    chk({tag, " data errors"}, bad_d, 0);
    chk({tag, " sof errors"}, bad_so, 0);
    chk({tag, " sol errors"}, bad_sl, 0);
    chk({tag, " chan errors"}, bad_ch, 0);
    chk({tag, " stall stability errors"}, bad_st, 0);
    chk({tag, " addrb lead errors"}, bad_ld, 0);
    chk({tag, " busy low at done"}, busy_b, 0);
    chk({tag, " valid low at done"}, valid_b, 0);
    if (exp_done_cyc != 0) chk({tag, " frame_done cycle"}, done_cyc, exp_done_cyc);
  endtask

  initial begin
    rst_n = 1'b0;
    start_b = 1'b0; ready_b = 1'b0;
    start_s = 1'b0; ready_s = 1'b0;

    // Per-cycle vectors for the small frame: row r is driven before edge r
    // and checked after it. Stalls at rows 4-6, 11, 17-18; start at row 9
    // arrives mid-frame and must be ignored.
    k = 0; pv = 0;
    for (int r = 0; r < NVEC; r++) begin
      vecs[r].start = (r == 0) || (r == 9);
      vecs[r].ready = !(r == 4 || r == 5 || r == 6 || r == 11 || r == 17 || r == 18);
      acc_now = pv && vecs[r].ready;
      if (acc_now) k++;
      vecs[r].exp_valid = (r >= 2) && (k < 24);
      vecs[r].exp_data  = 8'((1000 + k) % 256);
      vecs[r].exp_chan  = 2'(k % 3);
      vecs[r].exp_sof   = (k == 0);
      vecs[r].exp_sol   = (k % 12 == 0);
      vecs[r].exp_busy  = (k < 24);
      vecs[r].exp_done  = acc_now && (k == 24);
      pv = vecs[r].exp_valid;
    end

    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset big", 12'd0, busy_b, done_b, addr_b, valid_b, data_b, chan_b, sof_b, sol_b);
    chk_reset_vals("reset small", 12'd1000, busy_s, done_s, addr_s, valid_s, data_s, chan_s, sof_s, sol_s);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int r = 0; r < NVEC; r++) begin
      start_s = vecs[r].start;
      ready_s = vecs[r].ready;
      @(posedge clk); #1;
      chk($sformatf("vec%0d pix_valid", r), valid_s, vecs[r].exp_valid);
      chk($sformatf("vec%0d busy", r), busy_s, vecs[r].exp_busy);
      chk($sformatf("vec%0d frame_done", r), done_s, vecs[r].exp_done);
      if (vecs[r].exp_valid) begin
        chk($sformatf("vec%0d pix_data", r), data_s, vecs[r].exp_data);
        chk($sformatf("vec%0d pix_chan", r), chan_s, vecs[r].exp_chan);
        chk($sformatf("vec%0d pix_sof", r), sof_s, vecs[r].exp_sof);
        chk($sformatf("vec%0d pix_sol", r), sol_s, vecs[r].exp_sol);
      end
    end
    start_s = 1'b0;
    chk("small addrb holds last", addr_s, 1023);

    // Full-rate frame with an ignored mid-frame start, then a 30% frame
    // whose start coincides with the first frame's frame_done cycle.
    run_frame(100, 1'b1, 3074, "full");
    run_frame(30, 1'b0, 0, "r30");

    // Reset in the middle of a stalled frame on both instances.
    start_b = 1'b1; start_s = 1'b1;
    ready_b = 1'b0; ready_s = 1'b0;
    @(posedge clk); #1;
    start_b = 1'b0; start_s = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("pre-reset valid small", valid_s, 1);
    chk("pre-reset data small", data_s, 8'hE8);
    chk("pre-reset busy big", busy_b, 1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("midreset big", 12'd0, busy_b, done_b, addr_b, valid_b, data_b, chan_b, sof_b, sol_b);
    chk_reset_vals("midreset small", 12'd1000, busy_s, done_s, addr_s, valid_s, data_s, chan_s, sof_s, sol_s);
    #2 rst_n = 1'b1;
    ready_b = 1'b1; ready_s = 1'b1;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (valid_b || valid_s || busy_b || busy_s) seen++;
    end
    chk("post-reset needs fresh start", seen, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fb_scanout.md
# fb_scanout

Scan-out stage directly downstream of the 4096×8 framebuffer. It reads the framebuffer through its read port (addrb/doutb, one-cycle registered read latency) in raster order. It delivers the bytes as a valid/ready pixel stream with frame, row and channel markers to the LED driver. It sustains one byte per clock with full backpressure support and never drops or duplicates a byte.

## Interface
Parameters:
- COLS, 32: pixels per row
- ROWS, 32: rows per frame
- CHANS, 3: bytes per pixel (colour channels)
- BASE_ADDR, 0: framebuffer address of first byte. Elaboration error if BASE_ADDR + COLS·ROWS·CHANS > 4096.

Ports:
- clkb  in  1  single clock for the whole block (same clock as framebuffer port B)
- reset  in  1  asynchronous, active-low reset
- start  in  1  frame request pulse; honoured only when busy=0
- busy  out  1  frame scan in progress
- frame_done  out  1  one-cycle pulse on acceptance of the final byte
- addrb  out  12  framebuffer read address (registered)
- doutb  in  8  framebuffer read data, valid the cycle after addrb is sampled
- pix_data  out  8  pixel byte
- pix_chan  out  2  channel index 0..CHANS-1 of pix_data
- pix_sof  out  1  marks first byte of frame
- pix_sol  out  1  marks first byte of each row
- pix_valid  out  1  pix_data and markers valid
- pix_ready  in  1  consumer accepts when pix_valid & pix_ready

## Operation
- Reset values: busy=0, frame_done=0, addrb=BASE_ADDR, pix_valid=0, pix_data=0, pix_chan=0, pix_sof=0, pix_sol=0. Reset clears all counters, FIFO contents and any in-flight read, including mid-frame. The first frame after release requires a fresh start.
- States:
  - IDLE: start → ISSUE.
  - ISSUE: issues reads; after the last address is issued → DRAIN.
  - DRAIN: waits until the last byte is accepted → IDLE, pulsing frame_done.
- Counters: chan 0..CHANS-1, col 0..COLS-1, row 0..ROWS-1, nested in that order (chan fastest). addrb increments by 1 per issued read, from BASE_ADDR to BASE_ADDR + COLS·ROWS·CHANS − 1, with no wrap inside a frame.
- Marker bits (sof, sol, chan) travel with each read through the latency stage and the FIFO alongside the data:
  - sof = row 0, col 0, chan 0
  - sol = col 0, chan 0
- Output buffering: 2-entry FIFO. A read is issued in a cycle only if (FIFO occupancy + in-flight reads) < 2, counting the byte being popped that cycle as freed. This guarantees no overflow under arbitrary pix_ready.
- The addrb register advances only on issue. When not issuing, addrb holds its value; it holds its final value in DRAIN and IDLE until the next start reloads BASE_ADDR.
- start while busy=1 is ignored. start coincident with the frame_done cycle is accepted, since busy is already 0 in that cycle.

## Timing
- start sampled at edge 0 → addrb=BASE_ADDR and busy=1 after edge 0 → doutb valid after edge 1 → pix_valid=1 after edge 2. First-byte latency is therefore 2 cycles.
- With pix_ready held high: one byte per cycle, and a frame of N = COLS·ROWS·CHANS bytes completes with frame_done in cycle N+2 after start.
- pix_ready low: pix_valid and pix_data stay stable until accepted. Issue stalls once the FIFO plus in-flight count reaches 2. Output resumes the cycle after pix_ready rises, with no bubble.
- frame_done and busy=0 take effect in the cycle after the final handshake edge.

## Structure
- Shared package fb_pkg:
  - FB_ADDR_W=12, FB_DATA_W=8, FB_DEPTH=4096
  - struct fb_pix_t {data, chan, sof, sol}, shared with the upstream framebuffer writer.
- One sub-module: fb_skid_fifo, a 2-entry valid/ready FIFO of fb_pix_t exposing its occupancy count.
- The FSM, counters and issue logic live in fb_scanout.

## Test plan
- Reset then start, pix_ready=1, memory preloaded with addr[7:0]: 3072 bytes 0x00,0x01,… in order. pix_sof only on byte 0; pix_sol every 96 bytes. frame_done in cycle 3074 after start.
- pix_ready random at 30% duty: byte sequence identical to the pix_ready=1 case, with no drops or duplicates. pix_data stays stable while stalled, and addrb never runs more than 2 ahead of acceptance.
- start pulsed mid-frame: ignored, the frame continues unchanged. start coincident with frame_done: the next frame begins with addrb=BASE_ADDR on the following cycle.
- reset asserted mid-frame with pix_ready=0: all outputs return to reset values immediately. After release, pix_valid stays 0 until a new start.
- BASE_ADDR=1000, COLS=4, ROWS=2, CHANS=3: 24 bytes read from addresses 1000..1023. pix_chan cycles 0,1,2 and pix_sol is asserted at bytes 0 and 12.
